adder: RTL and testbench

- Registered carry-lookahead adder: adds two WIDTH-bit operands plus carry-in.
- Returns sum, carry-out, per-bit propagate/generate vectors and word-level group propagate/generate for cascading.
- Arithmetic core of the 74xx181-style ALU datapath.
- One pipeline register stage on the outputs; latency is 1 clock.

---
 rtl/adder.sv | 129 ++++++++++++
 tb/tb_adder.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/adder.sv
// Registered carry-lookahead adder.
// Adds two WIDTH-bit unsigned operands plus carry-in and registers the sum, the carry-out,
// the per-bit propagate/generate vectors and the word-level group propagate/generate used
// for cascading.
// Inside each 4-bit block the carries are flattened sum-of-products with no bit-to-bit
// ripple. The 4-bit blocks are chained through their block carries.
// Latency is one clock. One operation is accepted per cycle.
// WIDTH must be a multiple of 4 and at least 4.

module adder #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic [WIDTH-1:0] p,
  output logic [WIDTH-1:0] g,
  output logic             gp,
  output logic             gg
);

  localparam int unsigned NBLK = WIDTH / 4;

  // Combinational core results.
  logic [WIDTH-1:0] p_c;
  logic [WIDTH-1:0] g_c;
  logic [WIDTH-1:0] sum_c;
  logic             cout_c;
  logic             gp_c;
  logic             gg_c;

  // Per-block group propagate/generate, and the carry into each block.
  logic [NBLK-1:0]  blk_p;
  logic [NBLK-1:0]  blk_g;
  logic [NBLK-1:0]  blk_c;

  // Output pipeline registers.
  logic             out_valid_q;
  logic [WIDTH-1:0] sum_q;
  logic             cout_q;
  logic [WIDTH-1:0] p_q;
  logic [WIDTH-1:0] g_q;
  logic             gp_q;
  logic             gg_q;

  assign p_c = a ^ b;
  assign g_c = a & b;

  for (genvar k = 0; k < NBLK; k++) begin : gen_blk
    logic [3:0] bp;
    logic [3:0] bg;
    logic       ci;
    logic [3:0] c;

    assign bp = p_c[4*k +: 4];
    assign bg = g_c[4*k +: 4];
    assign ci = blk_c[k];

    // Flattened lookahead: every carry is a direct function of g, p and the block carry-in.
    assign c[0] = ci;
    assign c[1] = bg[0] | (bp[0] & ci);
    assign c[2] = bg[1] | (bp[1] & bg[0]) | (bp[1] & bp[0] & ci);
    assign c[3] = bg[2] | (bp[2] & bg[1]) | (bp[2] & bp[1] & bg[0])
                | (bp[2] & bp[1] & bp[0] & ci);

    assign sum_c[4*k +: 4] = bp ^ c;

    assign blk_p[k] = &bp;
    assign blk_g[k] = bg[3] | (bp[3] & bg[2]) | (bp[3] & bp[2] & bg[1])
                    | (bp[3] & bp[2] & bp[1] & bg[0]);
  end

  // Chain the block carries: the carry into block k+1 is the carry out of block k.
  always_comb begin
    blk_c    = '0;
    blk_c[0] = cin;
    for (int k = 0; k < int'(NBLK) - 1; k++) begin
      blk_c[k+1] = blk_g[k] | (blk_p[k] & blk_c[k]);
    end
  end

  // Word-level group signals. gg is the block chain evaluated with a zero carry-in.
  always_comb begin
    logic z;
    z = 1'b0;
    for (int k = 0; k < int'(NBLK); k++) begin
      z = blk_g[k] | (blk_p[k] & z);
    end
    gg_c   = z;
    gp_c   = &p_c;
    cout_c = gg_c | (gp_c & cin);
  end

  // Output stage. The data registers load every cycle, and out_valid qualifies the data.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      sum_q       <= '0;
      cout_q      <= 1'b0;
      p_q         <= '0;
      g_q         <= '0;
      gp_q        <= 1'b0;
      gg_q        <= 1'b0;
    end else begin
      out_valid_q <= in_valid;
      sum_q       <= sum_c;
      cout_q      <= cout_c;
      p_q         <= p_c;
      g_q         <= g_c;
      gp_q        <= gp_c;
      gg_q        <= gg_c;
    end
  end

  assign out_valid = out_valid_q;
  assign sum       = sum_q;
  assign cout      = cout_q;
  assign p         = p_q;
  assign g         = g_q;
  assign gp        = gp_q;
  assign gg        = gg_q;

endmodule

// File: tb/tb_adder.sv
// Self-checking bench for adder. It instantiates one 4-bit copy and one 8-bit copy.
// Expected results come from constant tables taken from the test plan and from a plain
// arithmetic model of a + b + cin.

module tb_adder;

  typedef struct {
    logic [7:0] sum;
    logic       cout;
    logic [7:0] p;
    logic [7:0] g;
    logic       gp;
    logic       gg;
  } res_t;

  typedef struct {
    logic [3:0] a;
    logic [3:0] b;
    logic       cin;
    res_t       exp;
  } vec_t;

  logic clk = 1'b0;
  logic rst;

  logic       iv4, cin4, ov4, co4, gp4, gg4;
  logic [3:0] a4, b4, s4, p4, g4;
  logic       iv8, cin8, ov8, co8, gp8, gg8;
  logic [7:0] a8, b8, s8, p8, g8;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  adder #(.WIDTH(4)) dut4 (
    .clk(clk), .rst(rst), .in_valid(iv4), .a(a4), .b(b4), .cin(cin4),
    .out_valid(ov4), .sum(s4), .cout(co4), .p(p4), .g(g4), .gp(gp4), .gg(gg4)
  );

  adder #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .in_valid(iv8), .a(a8), .b(b8), .cin(cin8),
    .out_valid(ov8), .sum(s8), .cout(co8), .p(p8), .g(g8), .gp(gp8), .gg(gg8)
  );

  // Reference: unsigned arithmetic on wide integers.
  function automatic res_t model(input int w, input int av, input int bv, input int ci);
    res_t r;
    int   mask;
    int   total;
    mask   = (1 << w) - 1;
    total  = av + bv + ci;
    r.sum  = 8'(total & mask);
    r.cout = ((total >> w) & 1) != 0;
    r.gg   = (((av + bv) >> w) & 1) != 0;
    r.p    = 8'((av ^ bv) & mask);
    r.g    = 8'(av & bv & mask);
    r.gp   = ((av ^ bv) & mask) == mask;
    return r;
  endfunction

  function automatic res_t zero_res();
    res_t r;
    r.sum = '0; r.cout = 1'b0; r.p = '0; r.g = '0; r.gp = 1'b0; r.gg = 1'b0;
    return r;
  endfunction

  function automatic res_t get4();
    res_t r;
    r.sum = {4'b0, s4}; r.cout = co4; r.p = {4'b0, p4}; r.g = {4'b0, g4};
    r.gp = gp4; r.gg = gg4;
    return r;
  endfunction

  function automatic res_t get8();
    res_t r;
    r.sum = s8; r.cout = co8; r.p = p8; r.g = g8; r.gp = gp8; r.gg = gg8;
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic chk_res(input string tag, input res_t act, input res_t exp,
                         input logic av, input logic ev);
    chk($sformatf("%s.out_valid", tag), 32'(av), 32'(ev));
    chk($sformatf("%s.sum", tag), 32'(act.sum), 32'(exp.sum));
    chk($sformatf("%s.cout", tag), 32'(act.cout), 32'(exp.cout));
    chk($sformatf("%s.p", tag), 32'(act.p), 32'(exp.p));
    chk($sformatf("%s.g", tag), 32'(act.g), 32'(exp.g));
    chk($sformatf("%s.gp", tag), 32'(act.gp), 32'(exp.gp));
    chk($sformatf("%s.gg", tag), 32'(act.gg), 32'(exp.gg));
  endtask

  function automatic vec_t mk(input logic [3:0] av, input logic [3:0] bv, input logic ci,
                              input logic [3:0] s, input logic co, input logic [3:0] pv,
                              input logic [3:0] gv, input logic gpv, input logic ggv);
    vec_t v;
    v.a = av; v.b = bv; v.cin = ci;
    v.exp.sum = {4'b0, s}; v.exp.cout = co; v.exp.p = {4'b0, pv}; v.exp.g = {4'b0, gv};
    v.exp.gp = gpv; v.exp.gg = ggv;
    return v;
  endfunction

  vec_t tbl[8];
  res_t e4, e8;

  initial begin
    tbl[0] = mk(4'b0101, 4'b1000, 1'b0, 4'b1101, 1'b0, 4'b1101, 4'b0000, 1'b0, 1'b0);
    tbl[1] = mk(4'b0001, 4'b1100, 1'b1, 4'b1110, 1'b0, 4'b1101, 4'b0000, 1'b0, 1'b0);
    tbl[2] = mk(4'b0101, 4'b0010, 1'b1, 4'b1000, 1'b0, 4'b0111, 4'b0000, 1'b0, 1'b0);
    tbl[3] = mk(4'b0111, 4'b1110, 1'b0, 4'b0101, 1'b1, 4'b1001, 4'b0110, 1'b0, 1'b1);
    tbl[4] = mk(4'b1111, 4'b1000, 1'b0, 4'b0111, 1'b1, 4'b0111, 4'b1000, 1'b0, 1'b1);
    tbl[5] = mk(4'b1101, 4'b1001, 1'b1, 4'b0111, 1'b1, 4'b0100, 4'b1001, 1'b0, 1'b1);
    tbl[6] = mk(4'b1111, 4'b0000, 1'b1, 4'b0000, 1'b1, 4'b1111, 4'b0000, 1'b1, 1'b0);
    tbl[7] = mk(4'b1111, 4'b0000, 1'b0, 4'b1111, 1'b0, 4'b1111, 4'b0000, 1'b1, 1'b0);

    rst = 1'b1;
    iv4 = 1'b0; a4 = '0; b4 = '0; cin4 = 1'b0;
    iv8 = 1'b0; a8 = '0; b8 = '0; cin8 = 1'b0;
    #2;
    chk_res("reset4", get4(), zero_res(), ov4, 1'b0);
    chk_res("reset8", get8(), zero_res(), ov8, 1'b0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    // Stream the table back to back; each result is checked one edge after it is applied.
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      a4 = tbl[i].a; b4 = tbl[i].b; cin4 = tbl[i].cin; iv4 = 1'b1;
      @(posedge clk); #1;
      chk_res($sformatf("vec%0d", i), get4(), tbl[i].exp, ov4, 1'b1);
    end
    @(negedge clk);
    iv4 = 1'b0;
    @(posedge clk); #1;
    chk("valid_drop", 32'(ov4), 32'd0);
    chk("data_loads_when_invalid", 32'(s4), 32'hf);

    // Reset arrives between edges while an operation waits for its edge.
    @(negedge clk);
    a4 = tbl[3].a; b4 = tbl[3].b; cin4 = tbl[3].cin; iv4 = 1'b1;
    #2 rst = 1'b1;
    #1;
    chk_res("async_reset", get4(), zero_res(), ov4, 1'b0);
    repeat (2) begin
      @(posedge clk); #1;
      chk_res("reset_hold", get4(), zero_res(), ov4, 1'b0);
    end
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    chk_res("first_after_reset", get4(), tbl[3].exp, ov4, 1'b1);

    // Exhaustive at WIDTH=4. The 8-bit copy receives random operands in parallel.
    for (int n = 0; n < 512; n++) begin
      @(negedge clk);
      a4 = n[3:0]; b4 = n[7:4]; cin4 = n[8]; iv4 = 1'($urandom);
      a8 = 8'($urandom); b8 = 8'($urandom); cin8 = 1'($urandom); iv8 = 1'($urandom);
      e4 = model(4, int'(a4), int'(b4), int'(cin4));
      e8 = model(8, int'(a8), int'(b8), int'(cin8));
      @(posedge clk); #1;
      chk_res($sformatf("exh4_a%0h_b%0h_c%0d", a4, b4, cin4), get4(), e4, ov4, iv4);
      chk_res($sformatf("rnd8_a%0h_b%0h_c%0d", a8, b8, cin8), get8(), e8, ov8, iv8);
    end

    // Carry across the block boundary at WIDTH=8.
    @(negedge clk);
    a8 = 8'hff; b8 = 8'h01; cin8 = 1'b0; iv8 = 1'b1;
    @(posedge clk); #1;
    chk("w8_wrap.sum", 32'(s8), 32'h00);
    chk("w8_wrap.cout", 32'(co8), 32'd1);
    chk("w8_wrap.gg", 32'(gg8), 32'd1);
    chk("w8_wrap.gp", 32'(gp8), 32'd0);
    chk("w8_wrap.out_valid", 32'(ov8), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
